// File: rtl/cipher_byte_tx_if.sv
// rtl/cipher_byte_tx_if.sv - block-in / byte-out stream bundle for cipher_byte_tx
interface cipher_byte_tx_if #(
  parameter int NUM_BYTES = 16,
  parameter int CNT_W     = 16
);
  logic [NUM_BYTES*8-1:0] blk_data;
  logic                   blk_valid;
  logic                   blk_ready;
  logic [7:0]             byte_data;
  logic                   byte_valid;
  logic                   byte_ready;
  logic                   byte_last;
  logic                   busy;
  logic [CNT_W-1:0]       blk_count;

  modport master (
    output blk_data, blk_valid, byte_ready,
    input  blk_ready, byte_data, byte_valid, byte_last, busy, blk_count
  );

  modport slave (
    input  blk_data, blk_valid, byte_ready,
    output blk_ready, byte_data, byte_valid, byte_last, busy, blk_count
  );
endinterface

// File: rtl/cipher_byte_tx.sv
// rtl/cipher_byte_tx.sv - serializes 128-bit cipher blocks into a byte stream
// Holds one active block plus one pending block so consecutive blocks stream without bubbles.
module cipher_byte_tx #(
  parameter int NUM_BYTES = 16,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input logic              clk,
  input logic              rst_n,
  cipher_byte_tx_if.slave  bus
);
  localparam int W     = NUM_BYTES * 8;
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [W-1:0]     active_q;
  logic [W-1:0]     pend_q;
  logic             pend_valid;
  logic [IDX_W-1:0] idx;
  logic             byte_valid_q;
  logic             busy_q;
  logic [CNT_W-1:0] count_q;

  logic accept;
  logic beat;
  logic last_beat;

  assign accept    = bus.blk_valid && !pend_valid;
  assign beat      = byte_valid_q && bus.byte_ready;
  assign last_beat = beat && (idx == LAST_IDX);

  assign bus.blk_ready  = !pend_valid;
  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_last  = byte_valid_q && (idx == LAST_IDX);
  assign bus.busy       = busy_q;
  assign bus.blk_count  = count_q;

  // The emitted byte is always the edge of the active register that the shift moves toward.
  generate
    if (MSB_FIRST) begin : g_msb
      assign bus.byte_data = active_q[W-1 -: 8];
    end else begin : g_lsb
      assign bus.byte_data = active_q[7:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      active_q     <= '0;
      pend_q       <= '0;
      pend_valid   <= 1'b0;
      idx          <= '0;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      count_q      <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        active_q     <= bus.blk_data;
        idx          <= '0;
        byte_valid_q <= 1'b1;
        busy_q       <= 1'b1;
        state        <= SEND;
      end
    end else begin
      if (last_beat) begin
        count_q <= count_q + CNT_W'(1);
        idx     <= '0;
        if (pend_valid) begin
          active_q   <= pend_q;
          pend_valid <= 1'b0;
        end else if (accept) begin
          active_q <= bus.blk_data;
        end else begin
          byte_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end
      end else begin
        if (beat) begin
          active_q <= MSB_FIRST ? (active_q << 8) : (active_q >> 8);
          idx      <= idx + IDX_W'(1);
        end
        if (accept) begin
          pend_q     <= bus.blk_data;
          pend_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/cipher_byte_tx.md
Name: cipher_byte_tx

Overview:
Downstream of the AES encrypt pipeline. Takes completed 128-bit cipher blocks over a valid/ready handshake and streams them out one byte per beat over a second valid/ready interface, toward a UART or FIFO-style output sink. It holds one active block being serialized plus one pending block, so back-to-back blocks stream with no idle beats.

Parameters:
NUM_BYTES, 16, bytes per block; block width is NUM_BYTES*8.
MSB_FIRST, 1, 1: emit bits [127:120] first; 0: emit bits [7:0] first.
CNT_W, 16, width of the completed-block counter.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
blk_data  in  NUM_BYTES*8  cipher block from the encrypt stage
blk_valid  in  1  blk_data is valid
blk_ready  out  1  block accepted when blk_valid && blk_ready
byte_data  out  8  output byte
byte_valid  out  1  byte_data is valid
byte_ready  in  1  sink accepts a byte when byte_valid && byte_ready
byte_last  out  1  high with the final byte of each block
busy  out  1  active or pending block present
blk_count  out  CNT_W  count of fully transmitted blocks; wraps modulo 2^CNT_W

Behaviour:
- Reset (rst_n low, async): byte_valid=0, byte_data=0, byte_last=0, busy=0, blk_count=0, active and pending buffers empty, byte index=0, state IDLE. blk_ready=1 while in reset.
- Storage: an active shift register of NUM_BYTES*8 bits, a pending register with pend_valid, and a byte index counter 0..NUM_BYTES-1.
- blk_ready is combinational: blk_ready = !pend_valid. It does not depend on blk_valid.
- FSM has two states, IDLE and SEND.
- IDLE: on a block accept, load the active register, set index=0, go to SEND. byte_valid rises on the next cycle (latency 1 clock from accept to first byte).
- SEND: byte_valid=1. byte_data is the current byte: the top byte of the active register if MSB_FIRST=1, else the bottom byte.
- SEND, beat (byte_valid && byte_ready), not last: shift the active register by 8 toward the emitted end and increment index.
- byte_last = byte_valid && (index == NUM_BYTES-1).
- SEND, last beat: blk_count increments by 1 and index resets to 0. Then:
  - if pend_valid: move pending into active, clear pend_valid, stay in SEND;
  - else if a block is accepted in the same cycle: load it directly into active, stay in SEND;
  - else: go to IDLE and drop byte_valid next cycle.
- SEND, block accepted and not the last beat: store the block in pending and set pend_valid.
- Simultaneous last beat and accept with pend_valid=1 cannot occur, because blk_ready=0 in that case.
- Stability: while byte_valid && !byte_ready, byte_data, byte_last and all internal state hold. byte_ready while byte_valid=0 is ignored.
- busy = (state==SEND) || pend_valid.
- Back-to-back with byte_ready held high: one byte every cycle, with no bubble between blocks.
- blk_count wraps from 2^CNT_W-1 to 0.
- Reset mid-block: the partial block and any pending block are discarded, no byte_last is emitted, and blk_count is cleared.
- All outputs except blk_ready and byte_last are registered; byte_last is decoded from registered state only.

Test Plan:
- Single block, MSB_FIRST=1: blk_data=128'h3925841D02DC09FBDC118597196A0B32, byte_ready=1 -> bytes 39,25,84,1D,...,0B,32 on 16 consecutive cycles starting 1 cycle after accept; byte_last only on 32; blk_count=1; busy returns to 0.
- Backpressure: same block, byte_ready toggled 1,0,0,1,... -> each byte held stable while stalled; no byte lost or duplicated; 16 beats total; byte_last on the 16th beat only.
- Back-to-back: three blocks 128'h00..0F, 128'h10..1F, 128'h20..2F offered continuously with byte_ready=1 -> 48 bytes 00..2F on consecutive cycles; blk_ready low while pending is full; blk_count=3.
- Reset mid-block: assert rst_n=0 after 5 bytes with a pending block loaded -> byte_valid=0 and blk_count=0 immediately; after release, a new block 128'hFF..FF streams 16 FF bytes correctly.
- MSB_FIRST=0 with blk_data=128'h0F0E..0100 -> byte order 00,01,...,0F.
- CNT_W=2: send 5 blocks -> blk_count sequence 1,2,3,0,1.
